// File: rtl/key_access_pkg.sv
// Shared types and defaults for the serial-key access controller.
// Optional build macro used by the controller: ACCESS_TIMEOUT_EN.
package key_access_pkg;

    typedef enum logic [2:0] {
        IDLE,
        KEY,
        CHECK,
        ACTIVE,
        LOCKOUT
    } state_t;

    localparam int         DEF_KEY_LEN     = 4;
    localparam logic [3:0] DEF_KEY_VALUE   = 4'b1010;
    localparam int         DEF_MAX_FAIL    = 3;
    localparam int         DEF_LOCK_CYCLES = 16;
    localparam int         DEF_TIMEOUT     = 32;

    // Width needed to hold a failure count from 0 up to max_fail inclusive.
    function automatic int fail_cnt_w(input int max_fail);
        return $clog2(max_fail + 1);
    endfunction

endpackage

// File: rtl/key_access_ctrl_if.sv
// Bundle of key-entry, datapath-request and status signals for key_access_ctrl.
//
// Handshake semantics:
//   - InputKey is only meaningful in a cycle where BitValid=1; each such cycle
//     is one accepted bit while a key attempt is in progress (no back-pressure).
//   - Req[i]/Grant[i] form a hold-until-release request: a requester keeps
//     Req[i]=1 for as long as it needs the datapath, Grant[i] stays 1 until
//     Req[i] drops, and the grant is never taken away while Req[i] is held
//     (only Logout, timeout or Reset end it).
//   - Start, Logout are single-cycle-or-longer level commands sampled on Clk.
interface key_access_ctrl_if
    import key_access_pkg::*;
#(
    parameter int MAX_FAIL = DEF_MAX_FAIL
);
    logic                              Start;
    logic                              BitValid;
    logic                              InputKey;
    logic                              Logout;
    logic [1:0]                        Req;
    logic                              Active;
    logic                              Mode;
    logic [1:0]                        Grant;
    logic                              Locked;
    logic                              AuthFail;
    logic [fail_cnt_w(MAX_FAIL)-1:0]   FailCnt;
    state_t                            state_dbg;

    modport master (
        output Start, BitValid, InputKey, Logout, Req,
        input  Active, Mode, Grant, Locked, AuthFail, FailCnt, state_dbg
    );

    modport slave (
        input  Start, BitValid, InputKey, Logout, Req,
        output Active, Mode, Grant, Locked, AuthFail, FailCnt, state_dbg
    );

endinterface

// File: rtl/key_access_ctrl_rr_arbiter2.sv
// Two-requester round-robin arbiter: a grant is held until its request drops,
// then passes straight to the other requester if it is waiting.
module rr_arbiter2 (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Enable,
    input  logic [1:0] Req,
    output logic [1:0] Grant,
    output logic       Mode
);
    logic       last;
    logic [1:0] next_grant;

    // Choose the next owner: keep a held grant, otherwise serve whoever asks,
    // breaking a tie in favour of the requester that was not served last.
    always_comb begin
        next_grant = 2'b00;
        if (Grant[0] && Req[0]) begin
            next_grant = 2'b01;
        end else if (Grant[1] && Req[1]) begin
            next_grant = 2'b10;
        end else begin
            case (Req)
                2'b01:   next_grant = 2'b01;
                2'b10:   next_grant = 2'b10;
                2'b11:   next_grant = last ? 2'b01 : 2'b10;
                default: next_grant = 2'b00;
            endcase
        end
    end

    // Register grant, last-served pointer and Mode; Enable low drops the grant
    // but leaves Mode and the pointer untouched.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            Grant <= 2'b00;
            last  <= 1'b1;
            Mode  <= 1'b0;
        end else if (!Enable) begin
            Grant <= 2'b00;
        end else begin
            Grant <= next_grant;
            if (next_grant != 2'b00) begin
                last <= next_grant[1];
                Mode <= next_grant[1];
            end
        end
    end

endmodule

// File: rtl/key_access_ctrl.sv
// Serial-key access controller: frames a key, counts failures, enforces a
// timed lockout and, once unlocked, arbitrates the datapath between two
// requesters. Optional macro ACCESS_TIMEOUT_EN adds an idle auto-logout.
module key_access_ctrl
    import key_access_pkg::*;
#(
    parameter int                 KEY_LEN     = DEF_KEY_LEN,
    parameter logic [KEY_LEN-1:0] KEY_VALUE   = KEY_LEN'(DEF_KEY_VALUE),
    parameter int                 MAX_FAIL    = DEF_MAX_FAIL,
    parameter int                 LOCK_CYCLES = DEF_LOCK_CYCLES,
    parameter int                 TIMEOUT     = DEF_TIMEOUT
) (
    input  logic              Clk,
    input  logic              Reset,
    key_access_ctrl_if.slave  bus
);
    localparam int FCW = fail_cnt_w(MAX_FAIL);
    localparam int BCW = $clog2(KEY_LEN + 1);
    localparam int LCW = $clog2(LOCK_CYCLES + 1);

    if (TIMEOUT < 1 || LOCK_CYCLES < 1 || MAX_FAIL < 1) begin : g_bad_params
        $error("key_access_ctrl: TIMEOUT, LOCK_CYCLES and MAX_FAIL must be >= 1");
    end

    state_t             state;
    logic [KEY_LEN-1:0] shreg;
    logic [BCW-1:0]     bit_cnt;
    logic [FCW-1:0]     fail_cnt;
    logic [LCW-1:0]     lock_cnt;
    logic               active;
    logic               locked;
    logic               auth_fail;
    logic               timeout_hit;
    logic               arb_enable;

`ifdef ACCESS_TIMEOUT_EN
    localparam int TCW = $clog2(TIMEOUT + 1);
    logic [TCW-1:0] idle_cnt;
    logic           idle_now;

    assign idle_now    = (state == ACTIVE) && (bus.Grant == 2'b00) && (bus.Req == 2'b00);
    assign timeout_hit = idle_now && (idle_cnt == TCW'(TIMEOUT - 1));

    // Count consecutive idle ACTIVE cycles; any request or grant restarts it.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            idle_cnt <= '0;
        end else if (!idle_now || timeout_hit) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + TCW'(1);
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // The grant must vanish on the same edge that leaves ACTIVE.
    assign arb_enable = (state == ACTIVE) && !bus.Logout && !timeout_hit;

    rr_arbiter2 u_arb (
        .Clk    (Clk),
        .Reset  (Reset),
        .Enable (arb_enable),
        .Req    (bus.Req),
        .Grant  (bus.Grant),
        .Mode   (bus.Mode)
    );

    // Main controller FSM with registered status outputs.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            shreg     <= '0;
            bit_cnt   <= '0;
            fail_cnt  <= '0;
            lock_cnt  <= '0;
            active    <= 1'b0;
            locked    <= 1'b0;
            auth_fail <= 1'b0;
        end else begin
            auth_fail <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.Start) begin
                        state   <= KEY;
                        shreg   <= '0;
                        bit_cnt <= '0;
                    end
                end
                KEY: begin
                    if (bus.Start) begin
                        shreg   <= '0;
                        bit_cnt <= '0;
                    end else if (bus.BitValid) begin
                        shreg   <= (shreg << 1) | KEY_LEN'(bus.InputKey);
                        bit_cnt <= bit_cnt + BCW'(1);
                        if (bit_cnt == BCW'(KEY_LEN - 1)) begin
                            state <= CHECK;
                        end
                    end
                end
                CHECK: begin
                    if (shreg == KEY_VALUE) begin
                        state    <= ACTIVE;
                        active   <= 1'b1;
                        fail_cnt <= '0;
                    end else begin
                        auth_fail <= 1'b1;
                        fail_cnt  <= fail_cnt + FCW'(1);
                        if (fail_cnt == FCW'(MAX_FAIL - 1)) begin
                            state    <= LOCKOUT;
                            locked   <= 1'b1;
                            lock_cnt <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                LOCKOUT: begin
                    if (lock_cnt == LCW'(LOCK_CYCLES - 1)) begin
                        state    <= IDLE;
                        locked   <= 1'b0;
                        fail_cnt <= '0;
                    end else begin
                        lock_cnt <= lock_cnt + LCW'(1);
                    end
                end
                ACTIVE: begin
                    if (bus.Logout || timeout_hit) begin
                        state  <= IDLE;
                        active <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.Active    = active;
    assign bus.Locked    = locked;
    assign bus.AuthFail  = auth_fail;
    assign bus.FailCnt   = fail_cnt;
    assign bus.state_dbg = state;

endmodule
